pif_led_seq: RTL
================

Name: pif_led_seq

Overview:
- Register-programmable LED sequencer that drives the board's red/green LED pins.
- Sits directly upstream of the LED pins and downstream of the host register bus (I2C/SPI slave decode). It replaces the free-running flasher once the host has configured it.
- Generates a slow phase tick from the system clock and walks four LED phases (red-up, red-down, green-up, green-down).
- Each phase uses PWM at a host-selected duty, either fixed or breathing.

Parameters:
- TICK_DIV, 177333, system clocks per step tick (26.6 MHz / 150); benches override to 8.
- B, 5, PWM resolution in bits.
- CLEN, 18, tick counter width; must satisfy 2^CLEN > TICK_DIV.

Ports:
- Clk  input  1  system clock (osc domain).
- Rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  single-cycle register write strobe.
- wr_addr  input  2  register address: 0 CTRL, 1 DUTY, 2 STEPS.
- wr_data  input  8  write data.
- red  output  1  red LED drive, active low.
- green  output  1  green LED drive, active low.
- tick  output  1  one-cycle step-tick pulse.
- phase  output  2  current LED phase.
- busy  output  1  high while the FSM is in RUN.

Behaviour:
- Registers (all reset to 0):
  - CTRL[0] = enable; CTRL[1] = mode (0 breathe, 1 fixed).
  - DUTY[B-1:0] = fixed duty level.
  - STEPS[7:0] = ticks per phase; value 0 is treated as 256.
- Reset values: red=1, green=1, tick=0, phase=0, busy=0; FSM=IDLE; all counters and shadows at 0.
- FSM has two states:
  - IDLE to RUN when enable=1, sampled at the clock edge.
  - RUN to IDLE when enable=0. Phase, step counter and tick counter clear in the same cycle; LEDs are off (1) from the next cycle.
  - In IDLE the tick counter holds at TICK_DIV-1 and tick stays 0.
- Tick generator (RUN only):
  - Down-counter loaded with TICK_DIV-1 on IDLE-to-RUN entry.
  - When the count reaches 0, tick=1 for exactly one cycle and the counter reloads. Period is exactly TICK_DIV clocks.
  - The first tick occurs TICK_DIV clocks after busy rises.
- Step/phase advance, on each tick:
  - If step == STEPS-1 (mod 256): step is set to 0 and phase = phase+1 mod 4 (wraps 3 to 0).
  - Otherwise step = step+1.
- Shadowing:
  - mode and DUTY are copied into shadow registers on each tick and on RUN entry.
  - A register write that coincides with a tick is captured in the register but not in the shadow; it takes effect on the following tick.
  - STEPS is compared live.
- Level selection:
  - Breathe mode: level = step[B-1:0].
  - Fixed mode: level = shadow DUTY.
- PWM:
  - Free-running B-bit counter pwm_cnt, incrementing every clock in RUN and wrapping at 2^B.
  - led_on = (pwm_cnt < level). Level 0 means never on; level 2^B-1 means on 31 of 32 cycles.
- Outputs (registered, 1-cycle latency from led_on):
  - red = !((phase==0 & led_on) | (phase==1 & !led_on))
  - green = !((phase==2 & led_on) | (phase==3 & !led_on))
- Writes to unused addresses (3) are ignored.
- A write to CTRL in the same cycle that RUN is entered takes effect normally.
- Reset asserted mid-RUN returns every register and output to its reset value immediately (asynchronous).

Test Plan:
- Reset check: with TICK_DIV=8, assert Rst mid-RUN -> red=1, green=1, busy=0 and phase=0 immediately, with no clock edge required.
- Tick timing: write STEPS=2, then CTRL=1 -> busy rises; tick pulses every 8 clocks with the first at clock 8; phase goes 0,0,1,1,2,2,3,3,0 across successive ticks.
- Fixed duty: write CTRL=3, DUTY=8 -> in phase 0, red is low for exactly 8 of every 32 clocks and green stays high; in phase 2 the same holds with the colours swapped.
- Boundary duty: in fixed mode, DUTY=0 gives red constantly high in phase 0 and constantly low in phase 1; DUTY=31 gives red low 31 of 32 clocks in phase 0.
- Shadow timing: write DUTY=4 in the same cycle as a tick -> duty stays at the old value until the next tick, then red is low 4 of 32 clocks.
- Disable mid-phase: in RUN, phase=2, write CTRL=0 -> busy=0 and phase=0 next cycle, both LEDs high, no further ticks; re-enable -> first tick 8 clocks later and the sequence restarts at phase 0.

Source files
------------

// File: rtl/pif_led_seq.sv
// Register-programmable red/green LED sequencer: a slow step tick walks four
// LED phases, each driven by PWM at a fixed or breathing duty.
//
// state  | meaning
// S_IDLE | sequencer stopped, LEDs off, tick counter parked at TICK_DIV-1
// S_RUN  | tick generator, step/phase walk and PWM active
module pif_led_seq #(
    parameter int TICK_DIV = 177333,
    parameter int B        = 5,
    parameter int CLEN     = 18
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       red,
    output logic       green,
    output logic       tick,
    output logic [1:0] phase,
    output logic       busy
);

    localparam logic [CLEN-1:0] TICK_LOAD = CLEN'(TICK_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ctrl_q;
    logic [B-1:0]    duty_q;
    logic [7:0]      steps_q;
    logic [CLEN-1:0] tcnt_q, tcnt_d;
    logic            tick_q, tick_d;
    logic [7:0]      step_q, step_d;
    logic [1:0]      phase_q, phase_d;
    logic            mode_sh_q, mode_sh_d;
    logic [B-1:0]    duty_sh_q, duty_sh_d;
    logic [B-1:0]    pwm_q, pwm_d;
    logic            red_q, red_d;
    logic            green_q, green_d;
    logic [B-1:0]    level;
    logic            led_on;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl_q  <= '0;
            duty_q  <= '0;
            steps_q <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    ctrl_q  <= wr_data[1:0];
                2'd1:    duty_q  <= wr_data[B-1:0];
                2'd2:    steps_q <= wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        level     = mode_sh_q ? duty_sh_q : step_q[B-1:0];
        led_on    = (pwm_q < level);
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        tick_d    = 1'b0;
        step_d    = step_q;
        phase_d   = phase_q;
        mode_sh_d = mode_sh_q;
        duty_sh_d = duty_sh_q;
        pwm_d     = pwm_q;
        red_d     = 1'b1;
        green_d   = 1'b1;
        case (state_q)
            S_IDLE: begin
                tcnt_d = TICK_LOAD;
                pwm_d  = '0;
                if (ctrl_q[0]) begin
                    state_d   = S_RUN;
                    mode_sh_d = ctrl_q[1];
                    duty_sh_d = duty_q;
                end
            end
            S_RUN: begin
                red_d   = !((phase_q == 2'd0 && led_on) || (phase_q == 2'd1 && !led_on));
                green_d = !((phase_q == 2'd2 && led_on) || (phase_q == 2'd3 && !led_on));
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                    tcnt_d  = TICK_LOAD;
                    step_d  = '0;
                    phase_d = '0;
                    pwm_d   = '0;
                end else begin
                    pwm_d = pwm_q + 1'b1;
                    if (tcnt_q == '0) begin
                        // Shadows sample the register value from before any same-edge write.
                        tick_d    = 1'b1;
                        tcnt_d    = TICK_LOAD;
                        mode_sh_d = ctrl_q[1];
                        duty_sh_d = duty_q;
                        if (step_q == steps_q - 8'd1) begin
                            step_d  = '0;
                            phase_d = phase_q + 2'd1;
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            tick_q    <= 1'b0;
            step_q    <= '0;
            phase_q   <= '0;
            mode_sh_q <= 1'b0;
            duty_sh_q <= '0;
            pwm_q     <= '0;
            red_q     <= 1'b1;
            green_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            phase_q   <= phase_d;
            mode_sh_q <= mode_sh_d;
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
            red_q     <= red_d;
            green_q   <= green_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign tick  = tick_q;
    assign phase = phase_q;
    assign busy  = (state_q == S_RUN);

endmodule
